// File: rtl/ps2_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// ps2_cmd_sequencer
//
// Host-side command sequencer that sits between the requesters (CPU MMIO,
// lock-key logic) and the send path of the PS/2 controller. It arbitrates
// pending keyboard configuration requests (reset, LED set, typematic rate),
// issues the opcode/argument bytes, waits for the keyboard ACK, retries on
// RESEND or timeout, and strips protocol replies from the scan-code stream.
//
// Ports:
//   CLOCK_50                       system clock
//   reset                          asynchronous, active-high reset
//   kbd_reset_req                  pulse: request keyboard reset (0xFF)
//   led_req / led_val[2:0]         pulse: request LED update {caps,num,scroll}
//   rate_req / rate_val[6:0]       pulse: request typematic delay/rate set
//   the_command[7:0]               byte handed to the PS/2 controller
//   send_command                   send strobe to the PS/2 controller
//   command_was_sent               controller: byte transmitted
//   error_communication_timed_out  controller: transmit failed
//   received_data[7:0]             controller receive byte
//   received_data_en               receive byte valid
//   scan_data[7:0] / scan_en       filtered scan byte to the key decoder
//   busy                           a sequence is in progress
//   done / err                     one-cycle pulses: request completed/dropped
//   led_state[2:0]                 last LED value acknowledged by the keyboard
//
// Optional feature (macro PS2_AUTO_LED_EN): the forwarded scan stream is
// watched for the caps/num/scroll make codes; each one toggles an internal
// lock register and raises an LED request carrying the new lock value.
// ----------------------------------------------------------------------------
module ps2_cmd_sequencer #(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int BAT_TIMEOUT = 50_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       kbd_reset_req,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       rate_req,
    input  logic [6:0] rate_val,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] scan_data,
    output logic       scan_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] led_state
);

    localparam int AckW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int BatW   = (BAT_TIMEOUT > 1) ? $clog2(BAT_TIMEOUT) : 1;
    localparam int RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [AckW-1:0]   AckLast  = AckW'(ACK_TIMEOUT - 1);
    localparam logic [BatW-1:0]   BatLast  = BatW'(BAT_TIMEOUT - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, SEND_OP, WAIT_OP, SEND_ARG, WAIT_ARG, WAIT_BAT, RETRY, FINISH
    } state_e;

    typedef enum logic [1:0] {REQ_RESET, REQ_LED, REQ_RATE} req_e;

    state_e            state_q, state_d;
    req_e              curReq_q, curReq_d;
    logic [RetryW-1:0] retries_q, retries_d;
    logic [AckW-1:0]   ackTimer_q;
    logic [BatW-1:0]   batTimer_q;
    logic [7:0]        cmd_q, cmd_d;
    logic              resetPend_q, ledPend_q, ratePend_q;
    logic [2:0]        ledVal_q;
    logic [6:0]        rateVal_q;
    logic [7:0]        scanData_q;
    logic              scanEn_q, done_q, err_q;
    logic [2:0]        ledState_q;

    logic              doneEvt, errEvt, clearPend, ledAck, consumed;
    logic              autoReq;
    logic [2:0]        autoVal;
    logic              ledReqAny;
    logic [2:0]        ledValIn;

    logic rxFA, rxFE, rxAA, rxFC;
    assign rxFA = received_data_en && (received_data == 8'hFA);
    assign rxFE = received_data_en && (received_data == 8'hFE);
    assign rxAA = received_data_en && (received_data == 8'hAA);
    assign rxFC = received_data_en && (received_data == 8'hFC);

    // Next-state logic. Replies arriving in the same cycle as a timer expiry
    // take precedence, so a late-but-valid ACK is never thrown away.
    always_comb begin
        state_d   = state_q;
        curReq_d  = curReq_q;
        retries_d = retries_q;
        cmd_d     = cmd_q;
        doneEvt   = 1'b0;
        errEvt    = 1'b0;
        clearPend = 1'b0;
        ledAck    = 1'b0;
        consumed  = 1'b0;
        case (state_q)
            IDLE: begin
                if (resetPend_q) begin
                    curReq_d = REQ_RESET;
                    state_d  = SEND_OP;
                end else if (ledPend_q) begin
                    curReq_d = REQ_LED;
                    state_d  = SEND_OP;
                end else if (ratePend_q) begin
                    curReq_d = REQ_RATE;
                    state_d  = SEND_OP;
                end
                retries_d = '0;
            end
            SEND_OP, SEND_ARG: begin
                if (error_communication_timed_out) begin
                    state_d = RETRY;
                end else if (command_was_sent) begin
                    state_d = (state_q == SEND_OP) ? WAIT_OP : WAIT_ARG;
                end
            end
            WAIT_OP: begin
                if (rxFA) begin
                    consumed = 1'b1;
                    state_d  = (curReq_q == REQ_RESET) ? WAIT_BAT : SEND_ARG;
                end else if (rxFE) begin
                    consumed = 1'b1;
                    state_d  = RETRY;
                end else if (ackTimer_q == AckLast) begin
                    state_d = RETRY;
                end
            end
            WAIT_ARG: begin
                if (rxFA) begin
                    consumed = 1'b1;
                    state_d  = FINISH;
                end else if (rxFE) begin
                    consumed = 1'b1;
                    state_d  = RETRY;
                end else if (ackTimer_q == AckLast) begin
                    state_d = RETRY;
                end
            end
            WAIT_BAT: begin
                if (rxAA) begin
                    consumed = 1'b1;
                    state_d  = FINISH;
                end else if (rxFC || (batTimer_q == BatLast)) begin
                    consumed  = rxFC;
                    errEvt    = 1'b1;
                    clearPend = 1'b1;
                    retries_d = '0;
                    state_d   = IDLE;
                end
            end
            RETRY: begin
                if (retries_q < RetryMax) begin
                    retries_d = retries_q + RetryW'(1);
                    state_d   = SEND_OP;
                end else begin
                    errEvt    = 1'b1;
                    clearPend = 1'b1;
                    retries_d = '0;
                    state_d   = IDLE;
                end
            end
            FINISH: begin
                doneEvt   = 1'b1;
                clearPend = 1'b1;
                ledAck    = (curReq_q == REQ_LED);
                retries_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The command byte is captured on entry to a send state so it stays
        // stable for the whole handshake even if a requester updates its value.
        if ((state_d == SEND_OP) && (state_q != SEND_OP)) begin
            case (curReq_d)
                REQ_RESET: cmd_d = 8'hFF;
                REQ_LED:   cmd_d = 8'hED;
                default:   cmd_d = 8'hF3;
            endcase
        end else if ((state_d == SEND_ARG) && (state_q != SEND_ARG)) begin
            case (curReq_d)
                REQ_LED:  cmd_d = {5'b0, ledVal_q};
                REQ_RATE: cmd_d = {1'b0, rateVal_q};
                default:  cmd_d = 8'h00;
            endcase
        end
    end

`ifdef PS2_AUTO_LED_EN
    logic [2:0] lock_q;
    logic       breakSeen_q, extSeen_q;
    logic       fwdByte;

    assign fwdByte = received_data_en && !consumed;

    // Only plain make codes count: anything after an F0 (break) or E0
    // (extended) prefix is skipped so key releases never toggle a lock.
    always_comb begin
        autoReq = 1'b0;
        autoVal = lock_q;
        if (fwdByte && !breakSeen_q && !extSeen_q) begin
            case (received_data)
                8'h58: begin autoReq = 1'b1; autoVal[2] = ~lock_q[2]; end
                8'h77: begin autoReq = 1'b1; autoVal[1] = ~lock_q[1]; end
                8'h7E: begin autoReq = 1'b1; autoVal[0] = ~lock_q[0]; end
                default: ;
            endcase
        end
    end

    // Lock register and prefix tracking; an explicit led_req always wins.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lock_q      <= 3'b000;
            breakSeen_q <= 1'b0;
            extSeen_q   <= 1'b0;
        end else begin
            lock_q <= led_req ? led_val : autoVal;
            if (fwdByte) begin
                if (received_data == 8'hF0) begin
                    breakSeen_q <= 1'b1;
                end else if (received_data == 8'hE0) begin
                    extSeen_q <= 1'b1;
                end else begin
                    breakSeen_q <= 1'b0;
                    extSeen_q   <= 1'b0;
                end
            end
        end
    end
`else
    assign autoReq = 1'b0;
    assign autoVal = 3'b000;
`endif

    assign ledReqAny = led_req | autoReq;
    assign ledValIn  = led_req ? led_val : autoVal;

    // State, timers, pending latches and registered outputs. A request pulse
    // in the same cycle as its sequence completes wins over the clear.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            curReq_q    <= REQ_RESET;
            retries_q   <= '0;
            ackTimer_q  <= '0;
            batTimer_q  <= '0;
            cmd_q       <= 8'h00;
            resetPend_q <= 1'b0;
            ledPend_q   <= 1'b0;
            ratePend_q  <= 1'b0;
            ledVal_q    <= 3'b000;
            rateVal_q   <= 7'h00;
            scanData_q  <= 8'h00;
            scanEn_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ledState_q  <= 3'b000;
        end else begin
            state_q   <= state_d;
            curReq_q  <= curReq_d;
            retries_q <= retries_d;
            cmd_q     <= cmd_d;

            if (state_d != state_q) begin
                ackTimer_q <= '0;
            end else if (((state_q == WAIT_OP) || (state_q == WAIT_ARG)) && (ackTimer_q != '1)) begin
                ackTimer_q <= ackTimer_q + AckW'(1);
            end
            if (state_d != state_q) begin
                batTimer_q <= '0;
            end else if ((state_q == WAIT_BAT) && (batTimer_q != '1)) begin
                batTimer_q <= batTimer_q + BatW'(1);
            end

            if (kbd_reset_req) begin
                resetPend_q <= 1'b1;
            end else if (clearPend && (curReq_q == REQ_RESET)) begin
                resetPend_q <= 1'b0;
            end
            if (ledReqAny) begin
                ledPend_q <= 1'b1;
                ledVal_q  <= ledValIn;
            end else if (clearPend && (curReq_q == REQ_LED)) begin
                ledPend_q <= 1'b0;
            end
            if (rate_req) begin
                ratePend_q <= 1'b1;
                rateVal_q  <= rate_val;
            end else if (clearPend && (curReq_q == REQ_RATE)) begin
                ratePend_q <= 1'b0;
            end

            scanData_q <= received_data;
            scanEn_q   <= received_data_en && !consumed;
            done_q     <= doneEvt;
            err_q      <= errEvt;
            if (ledAck) begin
                ledState_q <= ledVal_q;
            end
        end
    end

    assign the_command  = cmd_q;
    assign send_command = (state_q == SEND_OP) || (state_q == SEND_ARG);
    assign busy         = (state_q != IDLE);
    assign scan_data    = scanData_q;
    assign scan_en      = scanEn_q;
    assign done         = done_q;
    assign err          = err_q;
    assign led_state    = ledState_q;

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
- Host-side command sequencer between requesters (CPU MMIO, lock-key logic) and the PS/2 controller's send path.
- Arbitrates pending keyboard configuration requests: keyboard reset, LED set and typematic rate.
- Issues opcode/argument bytes, waits for ACK, retries on RESEND or timeout.
- Filters protocol replies out of the scan-code stream forwarded to the key decoder.

Parameters:
- ACK_TIMEOUT, 1_000_000: cycles to wait for a reply after each byte is sent (20 ms at 50 MHz).
- BAT_TIMEOUT, 50_000_000: cycles to wait for the self-test result after the reset ACK.
- MAX_RETRY, 3: resends allowed per request before it is dropped with err.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- kbd_reset_req  in  1  pulse; request keyboard reset (0xFF)
- led_req  in  1  pulse; request LED update using led_val
- led_val  in  3  {caps, num, scroll}
- rate_req  in  1  pulse; request typematic set using rate_val
- rate_val  in  7  typematic delay/rate argument
- the_command  out  8  byte to the PS/2 controller
- send_command  out  1  send strobe to the PS/2 controller
- command_was_sent  in  1  PS/2 controller: byte transmitted
- error_communication_timed_out  in  1  PS/2 controller: transmit failed
- received_data  in  8  PS/2 controller receive byte
- received_data_en  in  1  receive byte valid
- scan_data  out  8  filtered scan byte to the key decoder
- scan_en  out  1  scan_data valid
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse; request completed
- err  out  1  one-cycle pulse; request dropped
- led_state  out  3  last LED value acknowledged by the keyboard

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0; pending requests, retry count and timers are cleared. Reset mid-sequence abandons the sequence without a final byte.
- Each request type has a one-deep pending latch. A new pulse while pending overwrites the latched value. A pulse in the same cycle as done/err is latched, not lost.
- Arbitration happens in IDLE only. Priority: reset > led > rate. The pending bit clears on done or err of its sequence.
- Sequences:
  - reset: FF, then wait for FA, then wait for AA.
  - led: ED, then FA, then {5'b0, led_val}, then FA.
  - rate: F3, then FA, then {1'b0, rate_val}, then FA.
- States: IDLE, SEND_OP, WAIT_OP, SEND_ARG, WAIT_ARG, WAIT_BAT, RETRY, FINISH.
- SEND_*: the_command is held stable; send_command stays high until command_was_sent or error_communication_timed_out, then drops for at least 1 cycle. A transmit timeout goes to RETRY.
- WAIT_*: the timer starts at 0 on entry.
  - FA advances the sequence.
  - FE goes to RETRY.
  - Any other byte is ignored and passed through.
  - Timer reaching ACK_TIMEOUT-1 goes to RETRY.
- WAIT_BAT: AA goes to FINISH; FC, or timer reaching BAT_TIMEOUT-1, goes to err.
- RETRY: if retries < MAX_RETRY, increment and return to SEND_OP (the whole sequence restarts). Otherwise pulse err, drop the request, go to IDLE.
- FINISH: pulse done; led_state <= latched led_val for an LED sequence; retries <= 0; go to IDLE.
- busy is 1 in every state except IDLE.
- Scan path is registered, 1-cycle latency.
  - scan_data = received_data.
  - scan_en = received_data_en, except 0 when the byte is consumed as a reply (FA/FE in WAIT_OP/WAIT_ARG, AA/FC in WAIT_BAT).
  - FA/FE/AA received in IDLE pass through.
- Timers are saturating counters of width $clog2 of the parameter.

Optional Feature:
- Macro: PS2_AUTO_LED_EN.
- Defined:
  - Tracks make codes 58 (caps), 77 (num) and 7E (scroll) on the scan path. A code preceded by F0 is ignored; E0-prefixed codes are not matched.
  - Each match toggles the corresponding bit of an internal lock register and raises an internal led request with that value.
  - The internal request ORs with led_req. An external led_req overwrites the lock register with led_val.
- Undefined: no tracking logic; LEDs change only via led_req.

Test Plan:
- led_req with led_val=3'b101, keyboard replies FA, FA -> the_command sequence ED, 05; done pulses once; led_state=5; scan_en never asserted for either FA.
- rate_req with rate_val=7'h20, first reply FE, then FA, FA -> F3 sent twice, then 20; done pulses; retries reset to 0.
- kbd_reset_req with no reply at all -> FF sent 1+MAX_RETRY=4 times, each after ACK_TIMEOUT cycles; err pulses once; busy falls; no done.
- kbd_reset_req and led_req in the same cycle, all replies good (FA, AA, FA, FA) -> FF first, then ED; done pulses twice; AA not forwarded.
- Asynchronous reset asserted during WAIT_ARG of an LED sequence -> outputs 0 immediately; LED request gone; subsequent FA in IDLE forwarded on scan_en.
- With PS2_AUTO_LED_EN defined: bytes 58, then F0 58 -> single ED/04 sequence; the break does not toggle. Without the macro: no command is sent.
